// File: rtl/disc_pkg.sv
// Shared types and helpers for the discrete clock generator.
package disc_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StHigh,
    StLow
  } disc_state_e;

  // Half-period counter width; at least one bit even when HALF_PERIOD is 1.
  function automatic int unsigned hc_width(input int unsigned half_period);
    return (half_period > 1) ? $clog2(half_period) : 1;
  endfunction

endpackage

// File: rtl/disc_clk_gen.sv
// Discrete clock generator: divides CLK_DRV into a 50% duty CLK_OUT with
// edge strobes and a wrapping falling-edge counter.
// Define DISC_CLK_GEN_RISE_EN to generate the RISE strobe; otherwise RISE is 0.
module disc_clk_gen
  import disc_pkg::*;
#(
  parameter int unsigned HALF_PERIOD = 4,
  parameter int unsigned CNT_W       = 4
) (
  input  logic             CLK_DRV,
  input  logic             RST_N,
  input  logic             ENA,
  input  logic             SYNC_N,
  output logic             CLK_OUT,
  output logic             CLK_OUT_N,
  output logic             FALL,
  output logic             RISE,
  output logic [CNT_W-1:0] CNT,
  output logic             TC
);

  localparam int unsigned    HcW    = hc_width(HALF_PERIOD);
  localparam logic [HcW-1:0] HcLast = HcW'(HALF_PERIOD - 1);

  disc_state_e      state_q, state_d;
  logic [HcW-1:0]   hc_q, hc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fall_q, fall_d;
  logic             clk_q, clk_d;

  // Next-state logic: SYNC_N restart overrides the normal phase sequencing.
  always_comb begin
    state_d = state_q;
    hc_d    = hc_q;
    cnt_d   = cnt_q;
    fall_d  = 1'b0;
    if (!SYNC_N) begin
      state_d = ENA ? StHigh : StIdle;
      hc_d    = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          hc_d = '0;
          if (ENA) state_d = StHigh;
        end
        StHigh: begin
          if (!ENA) begin
            state_d = StIdle;
            hc_d    = '0;
          end else if (hc_q == HcLast) begin
            state_d = StLow;
            hc_d    = '0;
            fall_d  = 1'b1;
            cnt_d   = cnt_q + CNT_W'(1);
          end else begin
            hc_d = hc_q + HcW'(1);
          end
        end
        StLow: begin
          // A low phase always runs to completion; ENA only picks what follows.
          if (hc_q == HcLast) begin
            state_d = ENA ? StHigh : StIdle;
            hc_d    = '0;
          end else begin
            hc_d = hc_q + HcW'(1);
          end
        end
        default: begin
          state_d = StIdle;
          hc_d    = '0;
        end
      endcase
    end
    // Output clock is registered so it cannot glitch on state decoding.
    clk_d = (state_d != StLow);
  end

  // State, counters and registered outputs with synchronous reset.
  always_ff @(posedge CLK_DRV) begin
    if (!RST_N) begin
      state_q <= StIdle;
      hc_q    <= '0;
      cnt_q   <= '0;
      fall_q  <= 1'b0;
      clk_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      hc_q    <= hc_d;
      cnt_q   <= cnt_d;
      fall_q  <= fall_d;
      clk_q   <= clk_d;
    end
  end

`ifdef DISC_CLK_GEN_RISE_EN
  logic rise_q, rise_d;

  // Rise strobe marks the natural end of a low phase only.
  always_comb begin
    rise_d = SYNC_N && (state_q == StLow) && (hc_q == HcLast);
  end

  // Rise strobe register, cleared by reset.
  always_ff @(posedge CLK_DRV) begin
    if (!RST_N) begin
      rise_q <= 1'b0;
    end else begin
      rise_q <= rise_d;
    end
  end

  assign RISE = rise_q;
`else
  assign RISE = 1'b0;
`endif

  assign CLK_OUT   = clk_q;
  assign CLK_OUT_N = ~clk_q;
  assign FALL      = fall_q;
  assign CNT       = cnt_q;
  assign TC        = &cnt_q;

endmodule

// File: tb/tb_disc_clk_gen.sv
// Randomized bench for disc_clk_gen: two configurations (HALF_PERIOD 4 and 1)
// share stimulus and are each compared every cycle against a phase-position model.
module tb_disc_clk_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, ena, sync_n;

  logic       co0, con0, f0, r0, tc0;
  logic [3:0] cnt0;
  logic       co1, con1, f1, r1, tc1;
  logic [1:0] cnt1;

  disc_clk_gen #(.HALF_PERIOD(4), .CNT_W(4)) u_dut0 (
    .CLK_DRV  (clk),
    .RST_N    (rst_n),
    .ENA      (ena),
    .SYNC_N   (sync_n),
    .CLK_OUT  (co0),
    .CLK_OUT_N(con0),
    .FALL     (f0),
    .RISE     (r0),
    .CNT      (cnt0),
    .TC       (tc0)
  );

  disc_clk_gen #(.HALF_PERIOD(1), .CNT_W(2)) u_dut1 (
    .CLK_DRV  (clk),
    .RST_N    (rst_n),
    .ENA      (ena),
    .SYNC_N   (sync_n),
    .CLK_OUT  (co1),
    .CLK_OUT_N(con1),
    .FALL     (f1),
    .RISE     (r1),
    .CNT      (cnt1),
    .TC       (tc1)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Model: position within the 2*HP period; positions >= HP are the low phase.
  int hp_tab[2] = '{4, 1};
  int w_tab[2]  = '{4, 2};
  int m_run[2];
  int m_pos[2];
  int m_cnt[2];
  int m_fall[2];
  int m_rise[2];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_step(input int i, input bit r, input bit s, input bit e);
    int hp;
    hp        = hp_tab[i];
    m_fall[i] = 0;
    m_rise[i] = 0;
    if (!r) begin
      m_run[i] = 0;
      m_pos[i] = 0;
      m_cnt[i] = 0;
    end else if (!s) begin
      m_run[i] = e ? 1 : 0;
      m_pos[i] = 0;
      m_cnt[i] = 0;
    end else if (m_run[i] == 0) begin
      if (e) begin
        m_run[i] = 1;
        m_pos[i] = 0;
      end
    end else if (m_pos[i] < hp && !e) begin
      m_run[i] = 0;
      m_pos[i] = 0;
    end else begin
      m_pos[i] = (m_pos[i] + 1) % (2 * hp);
      if (m_pos[i] == hp) begin
        m_fall[i] = 1;
        m_cnt[i]  = (m_cnt[i] + 1) % (1 << w_tab[i]);
      end
      if (m_pos[i] == 0) begin
        m_rise[i] = 1;
        if (!e) m_run[i] = 0;
      end
    end
  endtask

  task automatic compare_all(input int i);
    int exp_clk, exp_rise, exp_tc;
    logic co, con, f, r, tc;
    logic [31:0] cnt;
    exp_clk = (m_run[i] != 0 && m_pos[i] >= hp_tab[i]) ? 0 : 1;
    exp_tc  = (m_cnt[i] == (1 << w_tab[i]) - 1) ? 1 : 0;
`ifdef DISC_CLK_GEN_RISE_EN
    exp_rise = m_rise[i];
`else
    exp_rise = 0;
`endif
    if (i == 0) begin
      co = co0; con = con0; f = f0; r = r0; tc = tc0; cnt = 32'(cnt0);
    end else begin
      co = co1; con = con1; f = f1; r = r1; tc = tc1; cnt = 32'(cnt1);
    end
    check_eq($sformatf("clk_out[%0d]", i), 32'(co), 32'(exp_clk));
    check_eq($sformatf("clk_out_n[%0d]", i), 32'(con), 32'(1 - exp_clk));
    check_eq($sformatf("fall[%0d]", i), 32'(f), 32'(m_fall[i]));
    check_eq($sformatf("rise[%0d]", i), 32'(r), 32'(exp_rise));
    check_eq($sformatf("cnt[%0d]", i), cnt, 32'(m_cnt[i]));
    check_eq($sformatf("tc[%0d]", i), 32'(tc), 32'(exp_tc));
    check_eq($sformatf("strobe_excl[%0d]", i), 32'(f & r), 32'd0);
  endtask

  initial begin
    rst_n  = 1'b0;
    ena    = 1'b0;
    sync_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      m_run[i] = 0; m_pos[i] = 0; m_cnt[i] = 0; m_fall[i] = 0; m_rise[i] = 0;
    end
    for (int c = 0; c < 5000; c++) begin
      cyc = c;
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
        model_step(i, rst_n, sync_n, ena);
        compare_all(i);
      end
      // Choose inputs to be sampled at the next edge.
      if (c < 2) begin
        rst_n = 1'b0;
      end else if (c < 300) begin
        // Long free run: exercises counter wrap and terminal count.
        rst_n  = 1'b1;
        ena    = 1'b1;
        sync_n = 1'b1;
      end else begin
        rst_n  = ($urandom_range(0, 299) != 0);
        sync_n = ($urandom_range(0, 79) != 0);
        if (c >= 2000 && c < 3000) begin
          if ($urandom_range(0, 3) == 0) ena = ~ena;
        end else begin
          if ($urandom_range(0, 29) == 0) ena = ~ena;
        end
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/disc_clk_gen.md
DISC_CLK_GEN -- requirements
Module: disc_clk_gen

Interface
REQ-001 SHALL have parameter HALF_PERIOD, default 4: CLK_DRV cycles per half-period of CLK_OUT; legal range 1..65535.
REQ-002 SHALL have parameter CNT_W, default 4: width of the falling-edge counter CNT; legal range 1..16.
REQ-003 CLK_DRV  input  1: the one clock; all state updates on its posedge.
REQ-004 RST_N  input  1: reset; synchronous and active-low.
REQ-005 ENA  input  1: run request; level-sensitive.
REQ-006 SYNC_N  input  1: synchronous phase restart; active-low.
REQ-007 CLK_OUT  output  1: generated discrete clock; idles high.
REQ-008 CLK_OUT_N  output  1: always ~CLK_OUT.
REQ-009 FALL  output  1: one-cycle strobe, high exactly in the cycle CLK_OUT first reads 0 after a 1.
REQ-010 RISE  output  1: one-cycle strobe, high exactly in the cycle CLK_OUT first reads 1 after a 0.
REQ-011 CNT  output  CNT_W: falling-edge count.
REQ-012 TC  output  1: terminal count, combinational AND of all CNT bits.

Function
REQ-013 SHALL implement a registered FSM with states IDLE, HIGH and LOW, plus a half-period counter HC of width max(1, clog2(HALF_PERIOD)).
REQ-014 In IDLE with ENA=1 sampled, the next state SHALL be HIGH with HC=0 and CLK_OUT held at 1.
REQ-015 In HIGH with ENA=1, HC SHALL increment each cycle; when HC==HALF_PERIOD-1 the next state SHALL be LOW, CLK_OUT=0, FALL=1, CNT=CNT+1, and HC=0.
REQ-016 In LOW, HC SHALL increment each cycle regardless of ENA; when HC==HALF_PERIOD-1 CLK_OUT SHALL return to 1 and RISE SHALL be 1; the next state SHALL be HIGH if ENA=1, else IDLE.
REQ-017 ENA=0 sampled in HIGH SHALL move to IDLE next cycle with HC=0, no edge, and no strobe; a low phase is never truncated.
REQ-018 With ENA held at 1, the CLK_OUT period SHALL be exactly 2*HALF_PERIOD cycles at 50% duty; the first FALL SHALL occur HALF_PERIOD cycles after the edge that sampled ENA=1 in IDLE.
REQ-019 CNT SHALL wrap from 2^CNT_W-1 to 0 on FALL; TC SHALL be 1 only while CNT is all ones.
REQ-020 SYNC_N=0 SHALL override ENA and set, next cycle, CLK_OUT=1, HC=0, CNT=0, and FALL=RISE=0, with no RISE even when forced out of LOW; the state SHALL be HIGH if ENA=1, else IDLE.
REQ-021 Priority SHALL be RST_N > SYNC_N > ENA.
REQ-022 With HALF_PERIOD=1, CLK_OUT SHALL toggle every cycle, and FALL and RISE SHALL alternate every cycle.
REQ-023 FALL and RISE SHALL never both be 1 in the same cycle.

Reset
REQ-024 While RST_N=0 at a posedge, the next state SHALL be IDLE, HC=0, CLK_OUT=1, CLK_OUT_N=0, FALL=0, RISE=0, CNT=0, TC=0 (TC=1 when CNT_W... never; CNT=0 gives TC=0 for all legal CNT_W).
REQ-025 Reset asserted mid-LOW SHALL abort the phase with no RISE strobe.

Configuration
REQ-026 Macro DISC_CLK_GEN_RISE_EN: when defined, RISE SHALL be generated as specified; when undefined, RISE SHALL be tied to 0 and its generating logic omitted, with all other behaviour unchanged.

Structure
REQ-027 Package disc_pkg SHALL hold the FSM state enum typedef (IDLE/HIGH/LOW) and a localparam function computing the HC width.
REQ-028 The design SHALL have no sub-module; the FSM, HC, and CNT SHALL reside in disc_clk_gen.

Verification
REQ-029 HALF_PERIOD=4, CNT_W=4, ENA=1 from cycle 0: FALL at cycles 4, 12, 20; RISE at cycles 8, 16; CLK_OUT high on cycles 0-3 and low on cycles 4-7.
REQ-030 Run 16 falls: CNT steps 1..15, TC=1 while CNT=15, and the 16th FALL wraps CNT to 0.
REQ-031 Drop ENA at cycle 5 (in LOW): CLK_OUT stays low until cycle 8, RISE at cycle 8, then IDLE with no further FALL; drop ENA at cycle 2: IDLE at cycle 3 with no strobe.
REQ-032 Pulse SYNC_N=0 at cycle 6 with ENA=1: CLK_OUT=1 and CNT=0 at cycle 7 with no RISE; next FALL at cycle 11.
REQ-033 HALF_PERIOD=1: CLK_OUT alternates 1,0,1,0; FALL is 1 on odd cycles and RISE on even cycles from cycle 2.
REQ-034 Assert RST_N=0 at cycle 5 in LOW: at cycle 6, CLK_OUT=1, CNT=0, and both strobes are 0.
